// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - binary32 field layout, constants and classification helpers
package fp_pkg;

    localparam int          MAN_W    = 23;
    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC00000;

    typedef struct packed {
        logic             sign;
        logic [7:0]       exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    function automatic logic is_nan(fp32_t x);
        return (x.exp == EXP_MAX) && (x.man != '0);
    endfunction

    function automatic logic is_inf(fp32_t x);
        return (x.exp == EXP_MAX) && (x.man == '0);
    endfunction

    function automatic logic is_zero(fp32_t x);
        return (x.exp == 8'd0) && (x.man == '0);
    endfunction

endpackage

// File: rtl/fp_adder_pipe_if.sv
// rtl/fp_adder_pipe_if.sv - operand/result strobe bundle for fp_adder_pipe
interface fp_adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic [WIDTH-1:0] o;
    logic             valid;

    modport master (output a, b, ready, input o, valid);
    modport slave  (input a, b, ready, output o, valid);
endinterface

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter; all-zero input yields IN_W
module fp_lzc #(
    parameter int IN_W  = 28,
    parameter int CNT_W = $clog2(IN_W) + 1
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Ascending scan: the highest set bit is the last to write the count.
    always_comb begin
        cnt_o = CNT_W'(IN_W);
        for (int i = 0; i < IN_W; i++) begin
            if (in_i[i]) cnt_o = CNT_W'(IN_W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_adder_pipe.sv
// rtl/fp_adder_pipe.sv - pipelined binary32 adder, RNE, LATENCY stages
// FP_ADDER_SUBNORMAL_EN: gradual underflow; otherwise flush-to-zero on inputs and results.
module fp_adder_pipe
    import fp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 11
) (
    input  logic           clk,
    input  logic           rst,
    fp_adder_pipe_if.slave bus
);

    if (WIDTH != 32) begin : g_width_chk
        $error("fp_adder_pipe: only WIDTH=32 is supported");
    end
    if (LATENCY < 4) begin : g_lat_chk
        $error("fp_adder_pipe: LATENCY must be >= 4");
    end

    // Returns {effective exponent, 24-bit significand with implicit bit}.
    function automatic logic [31:0] unpack(fp32_t x);
`ifdef FP_ADDER_SUBNORMAL_EN
        return {(x.exp == 8'd0) ? 8'd1 : x.exp, x.exp != 8'd0, x.man};
`else
        return (x.exp == 8'd0) ? 32'd0 : {x.exp, 1'b1, x.man};
`endif
    endfunction

    logic [LATENCY-1:0] vld_q;
    fp32_t              a_q, b_q;

    always_ff @(posedge clk) begin
        if (!rst) vld_q <= '0;
        else      vld_q <= {vld_q[LATENCY-2:0], bus.ready};
    end

    always_ff @(posedge clk) begin
        a_q <= fp32_t'(bus.a);
        b_q <= fp32_t'(bus.b);
    end

    logic        swap, eff_sub, s_big, spc_d;
    logic [31:0] ua, ub, spc_val_d;
    logic [7:0]  e_big, e_sml, e_diff;
    logic [23:0] m_big, m_sml;
    logic [26:0] sml_ext, sml_aln;

    always_comb begin
        ua      = unpack(a_q);
        ub      = unpack(b_q);
        swap    = {b_q.exp, b_q.man} > {a_q.exp, a_q.man};
        eff_sub = a_q.sign ^ b_q.sign;
        s_big   = swap ? b_q.sign : a_q.sign;
        {e_big, m_big} = swap ? ub : ua;
        {e_sml, m_sml} = swap ? ua : ub;
        e_diff  = e_big - e_sml;
        sml_ext = {m_sml, 3'b000};
        // Bits shifted past the guard/round positions collapse into the sticky LSB.
        if (e_diff >= 8'd26) sml_aln = {26'd0, |m_sml};
        else sml_aln = (sml_ext >> e_diff)
                     | {26'd0, |(sml_ext & ~(27'h7FFFFFF << e_diff))};
        spc_d     = 1'b1;
        spc_val_d = QNAN;
        if (is_nan(a_q) || is_nan(b_q) || (is_inf(a_q) && is_inf(b_q) && eff_sub)) spc_val_d = QNAN;
        else if (is_inf(a_q)) spc_val_d = a_q;
        else if (is_inf(b_q)) spc_val_d = b_q;
        else                  spc_d     = 1'b0;
    end

    logic        s2_sign, s2_sub, s2_spc;
    logic [7:0]  s2_exp;
    logic [26:0] s2_big, s2_sml;
    logic [31:0] s2_spc_val;

    always_ff @(posedge clk) begin
        s2_sign    <= s_big;
        s2_sub     <= eff_sub;
        s2_exp     <= e_big;
        s2_big     <= {m_big, 3'b000};
        s2_sml     <= sml_aln;
        s2_spc     <= spc_d;
        s2_spc_val <= spc_val_d;
    end

    logic [27:0] sum_d;
    logic [5:0]  lz_d;

    assign sum_d = s2_sub ? ({1'b0, s2_big} - {1'b0, s2_sml})
                          : ({1'b0, s2_big} + {1'b0, s2_sml});

    fp_lzc #(.IN_W(28)) u_lzc (
        .in_i  (sum_d),
        .cnt_o (lz_d)
    );

    logic        s3_sign, s3_sub, s3_spc;
    logic [7:0]  s3_exp;
    logic [27:0] s3_sum;
    logic [5:0]  s3_lz;
    logic [31:0] s3_spc_val;

    always_ff @(posedge clk) begin
        s3_sign    <= s2_sign;
        s3_sub     <= s2_sub;
        s3_exp     <= s2_exp;
        s3_sum     <= sum_d;
        s3_lz      <= lz_d;
        s3_spc     <= s2_spc;
        s3_spc_val <= s2_spc_val;
    end

    logic [5:0]         shamt;
    logic [27:0]        norm;
    logic [24:0]        mant_r;
    logic               rnd_up, uflow;
    logic signed [9:0]  e_res, e_fin;
    logic [31:0]        res;

    always_comb begin
`ifdef FP_ADDER_SUBNORMAL_EN
        // Stop normalizing at exponent 1 so tiny results land as subnormals.
        shamt = ({2'b00, s3_lz} > s3_exp) ? s3_exp[5:0] : s3_lz;
`else
        shamt = s3_lz;
`endif
        e_res  = $signed({2'b00, s3_exp}) + 10'sd1 - $signed({4'b0000, shamt});
        norm   = s3_sum << shamt;
        rnd_up = norm[3] & ((|norm[2:0]) | norm[4]);
        mant_r = {1'b0, norm[27:4]} + {24'd0, rnd_up};
        e_fin  = mant_r[24] ? e_res + 10'sd1 : e_res;
`ifdef FP_ADDER_SUBNORMAL_EN
        uflow  = 1'b0;
`else
        uflow  = (e_fin <= 10'sd0);
`endif
        if (s3_spc)                  res = s3_spc_val;
        else if (s3_sum == 28'd0)    res = {s3_sub ? 1'b0 : s3_sign, 31'd0};
        else if (e_fin >= 10'sd255)  res = {s3_sign, EXP_MAX, 23'd0};
        else if (uflow)              res = {s3_sign, 31'd0};
        else if (!mant_r[24] && !mant_r[23]) res = {s3_sign, 8'd0, mant_r[22:0]};
        else                         res = {s3_sign, e_fin[7:0], mant_r[22:0]};
    end

    logic [31:0] pre_o;

    if (LATENCY == 4) begin : g_no_dly
        assign pre_o = res;
    end else begin : g_dly
        logic [LATENCY-5:0][31:0] dly_q;
        always_ff @(posedge clk) begin
            dly_q[0] <= res;
            for (int i = 1; i < LATENCY - 4; i++) dly_q[i] <= dly_q[i-1];
        end
        assign pre_o = dly_q[LATENCY-5];
    end

    logic [31:0] o_q;

    always_ff @(posedge clk) begin
        if (!rst)                    o_q <= '0;
        else if (vld_q[LATENCY-2])   o_q <= pre_o;
    end

    assign bus.o     = o_q;
    assign bus.valid = vld_q[LATENCY-1];

endmodule

// File: tb/tb_fp_adder_pipe.sv
// tb/tb_fp_adder_pipe.sv - directed-vector self-checking bench for fp_adder_pipe
module tb_fp_adder_pipe;

    localparam int LAT = 11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fp_adder_pipe_if #(.WIDTH(32)) bus ();

    fp_adder_pipe #(.WIDTH(32), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] ve);
        int lat;
        bus.a = va;
        bus.b = vb;
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        lat = 1;
        while (!bus.valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        check(tag, bus.o, ve);
        tick();
        check({tag, "_pulse"}, {31'd0, bus.valid}, 32'd0);
        check({tag, "_hold"}, bus.o, ve);
    endtask

    logic [31:0] st_a [8];
    logic [31:0] st_e [8];

    initial begin
        int seen;
        st_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        st_e = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
        bus.a = '0;
        bus.b = '0;
        bus.ready = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_o", bus.o, 32'd0);
        rst = 1'b1;
        tick();

        run_one("mix_sign",   32'h3FA66666, 32'hC16CCCCD, 32'hC1580000);
        run_one("tie_even",   32'h3F800000, 32'h33800000, 32'h3F800000);
        run_one("tie_up",     32'h3F800000, 32'h34400000, 32'h3F800002);
        run_one("ovf_inf",    32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        run_one("inf_m_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000);
        run_one("nan_in",     32'h7FC00001, 32'h00000000, 32'h7FC00000);
        run_one("inf_fin",    32'h7F800000, 32'h3F800000, 32'h7F800000);
        run_one("cancel",     32'h3F800000, 32'hBF800000, 32'h00000000);
        run_one("nz_nz",      32'h80000000, 32'h80000000, 32'h80000000);
        run_one("pz_nz",      32'h00000000, 32'h80000000, 32'h00000000);
        run_one("one_one",    32'h3F800000, 32'h3F800000, 32'h40000000);
        run_one("two_m_one",  32'h40000000, 32'hBF800000, 32'h3F800000);
        run_one("sticky_sub", 32'h3F800000, 32'h8C800000, 32'h3F800000);
`ifdef FP_ADDER_SUBNORMAL_EN
        run_one("sub_diff",   32'h00800000, 32'h80400000, 32'h00400000);
        run_one("sub_tiny",   32'h00800001, 32'h80800000, 32'h00000001);
        run_one("sub_sum",    32'h00400000, 32'h00400000, 32'h00800000);
`else
        run_one("ftz_tiny",   32'h00800001, 32'h80800000, 32'h00000000);
        run_one("ftz_sum",    32'h00400000, 32'h00400000, 32'h00000000);
`endif

        for (int k = 0; k < 8; k++) begin
            bus.a = st_a[k];
            bus.b = 32'h3F800000;
            bus.ready = 1'b1;
            tick();
        end
        bus.ready = 1'b0;
        seen = 0;
        while (!bus.valid && seen < 40) begin
            tick();
            seen++;
        end
        for (int k = 0; k < 8; k++) begin
            check($sformatf("stream_v%0d", k), {31'd0, bus.valid}, 32'd1);
            check($sformatf("stream_o%0d", k), bus.o, st_e[k]);
            tick();
        end
        check("stream_end", {31'd0, bus.valid}, 32'd0);

        seen = 0;
        for (int k = 0; k < 6; k++) begin
            bus.a = st_a[k];
            bus.b = 32'h3F800000;
            bus.ready = 1'b1;
            tick();
            seen += int'(bus.valid);
        end
        bus.ready = 1'b0;
        repeat (2) begin
            tick();
            seen += int'(bus.valid);
        end
        rst = 1'b0;
        tick();
        check("midrst_valid", {31'd0, bus.valid}, 32'd0);
        check("midrst_o", bus.o, 32'd0);
        rst = 1'b1;
        repeat (20) begin
            tick();
            seen += int'(bus.valid);
        end
        check("midrst_stale", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
